// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge: adapts the cache refill / write-back port to a 32-bit
// AXI4 master. One read engine and one write engine run independently, each
// with at most one transaction in flight. Read data is never buffered.
module cache_axi_bridge #(
  parameter int         LINE_BYTES = 16,
  parameter logic [3:0] RID        = 4'd0,
  parameter logic [3:0] WID        = 4'd1
) (
  input  logic                    clk,
  input  logic                    resetn,
  // cache read side
  input  logic                    rd_req,
  input  logic [2:0]              rd_type,
  input  logic [31:0]             rd_addr,
  output logic                    rd_rdy,
  output logic                    ret_valid,
  output logic                    ret_last,
  output logic [31:0]             ret_data,
  // cache write side
  input  logic                    wr_req,
  input  logic [2:0]              wr_type,
  input  logic [31:0]             wr_addr,
  input  logic [3:0]              wr_wstrb,
  input  logic [LINE_BYTES*8-1:0] wr_data,
  output logic                    wr_rdy,
  // AXI AR
  output logic [3:0]              arid,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [31:0]             araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  // AXI R
  input  logic [3:0]              rid,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [31:0]             rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  // AXI AW
  output logic [3:0]              awid,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [31:0]             awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  // AXI W
  output logic                    wvalid,
  input  logic                    wready,
  output logic [31:0]             wdata,
  output logic [3:0]              wstrb,
  output logic                    wlast,
  // AXI B
  input  logic [3:0]              bid,
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [1:0]              bresp
);

  localparam int          BEATS     = LINE_BYTES / 4;
  localparam int          CW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int          OFF       = $clog2(LINE_BYTES);
  localparam logic [31:0] LINE_MASK = ~(32'(LINE_BYTES) - 32'd1);
  localparam logic [7:0]  LINE_LEN  = 8'(BEATS - 1);
  localparam logic [2:0]  T_LINE    = 3'b100;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_B} wstate_t;

  rstate_t r_rstate, w_rstate_nxt;
  wstate_t r_wstate, w_wstate_nxt;

  logic [31:0]             r_raddr;
  logic                    r_rline;
  logic [1:0]              r_rsize;
  logic [31:0]             r_waddr;
  logic                    r_wline;
  logic [1:0]              r_wsize;
  logic [3:0]              r_wstrb;
  logic [LINE_BYTES*8-1:0] r_wdata;
  logic [CW-1:0]           r_wcnt;

  logic       w_hazard;
  logic       w_rd_acc;
  logic       w_wr_acc;
  logic [7:0] w_awlen;
  logic       w_wlast;
  logic       w_unused;

  // Response codes and IDs carry nothing this bridge acts on.
  assign w_unused = ^{rid, rresp, bid, bresp};

  // A read may not overtake a write-back of the same line still in flight.
  assign w_hazard = (r_wstate != W_IDLE) && (rd_addr[31:OFF] == r_waddr[31:OFF]);
  assign w_rd_acc = rd_req && rd_rdy;
  assign w_wr_acc = wr_req && wr_rdy;

  // ---------------- read engine ----------------

  // read FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_rstate <= R_IDLE;
    else         r_rstate <= w_rstate_nxt;
  end

  // capture the accepted read request
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_raddr <= '0;
      r_rline <= 1'b0;
      r_rsize <= '0;
    end else if (w_rd_acc) begin
      r_raddr <= rd_addr;
      r_rline <= (rd_type == T_LINE);
      r_rsize <= rd_type[1:0];
    end
  end

  // read next-state and handshake outputs; R beats pass straight to the cache
  always_comb begin
    w_rstate_nxt = r_rstate;
    rd_rdy       = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    ret_valid    = 1'b0;
    ret_last     = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        rd_rdy = !w_hazard;
        if (rd_req && !w_hazard) w_rstate_nxt = R_AR;
      end
      R_AR: begin
        arvalid = 1'b1;
        if (arready) w_rstate_nxt = R_DATA;
      end
      R_DATA: begin
        rready    = 1'b1;
        ret_valid = rvalid;
        ret_last  = rvalid && rlast;
        if (rvalid && rlast) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  assign ret_data = rdata;
  assign arid     = RID;
  assign araddr   = r_rline ? (r_raddr & LINE_MASK) : r_raddr;
  assign arlen    = r_rline ? LINE_LEN : 8'd0;
  assign arsize   = r_rline ? 3'd2 : {1'b0, r_rsize};
  assign arburst  = 2'b01;

  // ---------------- write engine ----------------

  // write FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_wstate <= W_IDLE;
    else         r_wstate <= w_wstate_nxt;
  end

  // capture the accepted write request and step the W beat counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_waddr <= '0;
      r_wline <= 1'b0;
      r_wsize <= '0;
      r_wstrb <= '0;
      r_wdata <= '0;
      r_wcnt  <= '0;
    end else if (w_wr_acc) begin
      r_waddr <= wr_addr;
      r_wline <= (wr_type == T_LINE);
      r_wsize <= wr_type[1:0];
      r_wstrb <= wr_wstrb;
      r_wdata <= wr_data;
      r_wcnt  <= '0;
    end else if (r_wstate == W_DATA && wready) begin
      r_wcnt  <= w_wlast ? '0 : r_wcnt + CW'(1);
    end
  end

  // write next-state and handshake outputs
  always_comb begin
    w_wstate_nxt = r_wstate;
    wr_rdy       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        wr_rdy = 1'b1;
        if (wr_req) w_wstate_nxt = W_AW;
      end
      W_AW: begin
        awvalid = 1'b1;
        if (awready) w_wstate_nxt = W_DATA;
      end
      W_DATA: begin
        wvalid = 1'b1;
        if (wready && w_wlast) w_wstate_nxt = W_B;
      end
      W_B: begin
        bready = 1'b1;
        if (bvalid) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  assign w_awlen = r_wline ? LINE_LEN : 8'd0;
  assign w_wlast = (r_wstate == W_DATA) && (r_wcnt == w_awlen[CW-1:0]);

  assign awid    = WID;
  assign awaddr  = r_wline ? (r_waddr & LINE_MASK) : r_waddr;
  assign awlen   = w_awlen;
  assign awsize  = r_wline ? 3'd2 : {1'b0, r_wsize};
  assign awburst = 2'b01;
  assign wdata   = r_wdata[{r_wcnt, 5'd0} +: 32];
  assign wstrb   = r_wline ? 4'hF : r_wstrb;
  assign wlast   = w_wlast;

endmodule

// File: tb/tb_cache_axi_bridge.sv
// tb_cache_axi_bridge: random cache traffic against a randomly stalling AXI
// slave. A transaction-level model predicts AR/AW/W fields, returned read
// data and when rd_rdy / wr_rdy must be high (busy engines, line hazard).
module tb_cache_axi_bridge;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         rd_req = 1'b0;
  logic [2:0]   rd_type = 3'd0;
  logic [31:0]  rd_addr = 32'd0;
  logic         rd_rdy, ret_valid, ret_last;
  logic [31:0]  ret_data;
  logic         wr_req = 1'b0;
  logic [2:0]   wr_type = 3'd0;
  logic [31:0]  wr_addr = 32'd0;
  logic [3:0]   wr_wstrb = 4'd0;
  logic [127:0] wr_data = 128'd0;
  logic         wr_rdy;
  logic [3:0]   arid, awid;
  logic         arvalid, awvalid, wvalid, rready, bready, wlast;
  logic [31:0]  araddr, awaddr, wdata;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, awsize;
  logic [1:0]   arburst, awburst;
  logic [3:0]   wstrb;
  logic         arready, rvalid, rlast, awready, wready, bvalid;
  logic [3:0]   rid, bid;
  logic [31:0]  rdata;
  logic [1:0]   rresp, bresp;

  always #5 clk = ~clk;

  cache_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .arid(arid), .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rid(rid), .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .awid(awid), .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bid(bid), .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // slave memory contents: a fixed scramble of the word address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    return (w * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [2:0] rnd_type();
    case ($urandom_range(0, 3))
      0:       return 3'b000;
      1:       return 3'b001;
      2:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // ---------------- reference model state ----------------
  logic [42:0] exp_ar_q[$];   // {addr, len, size}
  logic [32:0] exp_r_q[$];    // {last, data}
  logic [42:0] exp_aw_q[$];
  logic [36:0] exp_w_q[$];    // {last, strb, data}
  bit          rd_busy, w_busy, aw_done, ar_due, aw_due;
  logic [27:0] w_line;

  // ---------------- slave state ----------------
  bit          r_on, b_pend;
  int          r_idx, r_total, b_dly;
  logic [31:0] r_base, cap_araddr;
  logic [7:0]  cap_arlen;
  bit          hs_ar, hs_r, hs_wl, hs_b;
  bit          drive_en = 1'b0;

  logic [31:0] pool [4] = '{32'h0000_0080, 32'h0000_0090, 32'h1C00_0020, 32'h0000_1000};

  // random cache-side requests, driven on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (drive_en) begin
        rd_req   = ($urandom_range(0, 2) == 0);
        rd_type  = rnd_type();
        rd_addr  = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 15));
        wr_req   = ($urandom_range(0, 3) == 0);
        wr_type  = rnd_type();
        wr_addr  = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 15));
        wr_wstrb = 4'($urandom);
        wr_data  = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        rd_req = 1'b0;
        wr_req = 1'b0;
      end
    end
  end

  // AXI slave and scoreboard: drive on the falling edge, then sample the
  // values that will be seen at the next rising edge
  initial begin
    logic [42:0] ea;
    logic [32:0] er;
    logic [36:0] ew;
    bit          exp_rdy;
    arready = 0; rvalid = 0; rdata = 0; rlast = 0; rresp = 0; rid = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        arready = 0; rvalid = 0; rlast = 0; awready = 0; wready = 0; bvalid = 0;
        r_on = 0; b_pend = 0; rd_busy = 0; w_busy = 0; aw_done = 0;
        ar_due = 0; aw_due = 0;
        exp_ar_q.delete(); exp_r_q.delete(); exp_aw_q.delete(); exp_w_q.delete();
      end else begin
        if (hs_ar) begin
          r_on = 1; r_base = cap_araddr; r_idx = 0;
          r_total = (cap_arlen > 8'd15) ? 16 : int'(cap_arlen) + 1;
        end
        if (hs_r) begin
          rvalid = 0; r_idx++;
          if (r_idx >= r_total) r_on = 0;
        end
        if (r_on && !rvalid && $urandom_range(0, 2) != 0) begin
          rvalid = 1;
          rdata  = mem_word(r_base + 32'(4 * r_idx));
          rlast  = (r_idx == r_total - 1);
          rresp  = 2'($urandom);
          rid    = 4'($urandom);
        end
        if (!rvalid) begin rdata = $urandom; rlast = 1'($urandom); end
        arready = ($urandom_range(0, 1) == 1);
        awready = ($urandom_range(0, 2) == 0);
        wready  = ($urandom_range(0, 1) == 1);
        if (hs_wl) begin b_pend = 1; b_dly = $urandom_range(0, 3); end
        if (hs_b)  begin bvalid = 0; b_pend = 0; end
        if (b_pend && !bvalid) begin
          if (b_dly == 0) begin bvalid = 1; bresp = 2'($urandom); bid = 4'($urandom); end
          else b_dly--;
        end
      end
      hs_ar = 0; hs_r = 0; hs_wl = 0; hs_b = 0;
      #1;
      if (!resetn) begin
        chk("rst_outs", {arvalid, awvalid, wvalid, rready, bready, ret_valid, ret_last, rd_rdy, wr_rdy},
            9'b000000011);
      end else begin
        exp_rdy = !rd_busy && !(w_busy && rd_addr[31:4] == w_line);
        chk("rd_rdy", rd_rdy, exp_rdy);
        chk("wr_rdy", wr_rdy, !w_busy);
        if (ar_due) chk("ar_latency", arvalid, 1'b1);
        if (aw_due) chk("aw_latency", awvalid, 1'b1);
        ar_due = 0; aw_due = 0;
        chk("ret_flags", {ret_valid, ret_last}, {rvalid && r_on, rvalid && r_on && rlast});

        hs_ar = arvalid && arready;
        hs_r  = rvalid && rready;
        hs_wl = wvalid && wready && wlast;
        hs_b  = bvalid && bready;

        if (hs_ar) begin
          chk("ar_pending", exp_ar_q.size() > 0, 1'b1);
          if (exp_ar_q.size() > 0) begin
            ea = exp_ar_q.pop_front();
            chk("ar_fields", {araddr, arlen, arsize, arburst, arid}, {ea, 2'b01, 4'd0});
          end
          cap_araddr = araddr; cap_arlen = arlen;
        end
        if (hs_r) begin
          chk("r_pending", exp_r_q.size() > 0, 1'b1);
          if (exp_r_q.size() > 0) begin
            er = exp_r_q.pop_front();
            chk("ret_beat", {ret_last, ret_data}, er);
            if (er[32]) rd_busy = 0;
          end
        end
        if (awvalid && awready) begin
          chk("aw_pending", exp_aw_q.size() > 0, 1'b1);
          if (exp_aw_q.size() > 0) begin
            ea = exp_aw_q.pop_front();
            chk("aw_fields", {awaddr, awlen, awsize, awburst, awid}, {ea, 2'b01, 4'd1});
          end
          aw_done = 1;
        end
        if (wvalid && wready) begin
          chk("w_after_aw", aw_done, 1'b1);
          chk("w_pending", exp_w_q.size() > 0, 1'b1);
          if (exp_w_q.size() > 0) begin
            ew = exp_w_q.pop_front();
            chk("w_beat", {wlast, wstrb, wdata}, ew);
          end
        end
        if (hs_b) w_busy = 0;

        if (rd_req && rd_rdy) begin
          rd_busy = 1; ar_due = 1;
          if (rd_type == 3'b100) begin
            exp_ar_q.push_back({rd_addr & 32'hFFFF_FFF0, 8'd3, 3'd2});
            for (int k = 0; k < 4; k++)
              exp_r_q.push_back({k == 3, mem_word((rd_addr & 32'hFFFF_FFF0) + 32'(4 * k))});
          end else begin
            exp_ar_q.push_back({rd_addr, 8'd0, {1'b0, rd_type[1:0]}});
            exp_r_q.push_back({1'b1, mem_word(rd_addr)});
          end
        end
        if (wr_req && wr_rdy) begin
          w_busy = 1; aw_due = 1; aw_done = 0; w_line = wr_addr[31:4];
          if (wr_type == 3'b100) begin
            exp_aw_q.push_back({wr_addr & 32'hFFFF_FFF0, 8'd3, 3'd2});
            for (int k = 0; k < 4; k++)
              exp_w_q.push_back({k == 3, 4'hF, wr_data[32*k +: 32]});
          end else begin
            exp_aw_q.push_back({wr_addr, 8'd0, {1'b0, wr_type[1:0]}});
            exp_w_q.push_back({1'b1, wr_wstrb, wr_data[31:0]});
          end
        end
      end
    end
  end

  // test sequence
  initial begin
    bit found, idle;
    repeat (3) @(negedge clk);
    #2 resetn = 1'b1;
    drive_en = 1'b1;
    repeat (2000) @(negedge clk);

    // reset in the middle of a line read, while beat 2 is on the bus
    found = 0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk); #2;
      if (r_on && r_idx == 1 && rvalid && r_total == 4) found = 1;
    end
    chk("midburst_found", found, 1'b1);
    if (found) begin
      drive_en = 1'b0;
      resetn   = 1'b0;
      #1;
      chk("rst_rready", rready, 1'b0);
      chk("rst_ret_valid", ret_valid, 1'b0);
      repeat (3) @(negedge clk);
      #2 resetn = 1'b1;
      drive_en = 1'b1;
    end
    repeat (2000) @(negedge clk);

    drive_en = 1'b0;
    idle = 0;
    for (int i = 0; i < 400 && !idle; i++) begin
      @(negedge clk); #2;
      idle = !rd_busy && !w_busy && exp_ar_q.size() == 0 && exp_r_q.size() == 0 &&
             exp_aw_q.size() == 0 && exp_w_q.size() == 0;
    end
    chk("drain", idle, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
